mall_gate_sensor: RTL and testbench

Front-end direction decoder for the mall occupancy counter. Two infrared beams across the doorway, A (street side) and B (mall side), are synchronised, debounced and decoded by a direction state machine. The block emits one single-cycle `entry_pulse` per complete inward passage and one `exit_pulse` per complete outward passage; these pulses feed the entry and exit counters. It also keeps a local saturating occupancy count that drives the door "full" lamp.

---
 rtl/mall_gate_sensor.sv | 171 +++++++++++++++++
 tb/tb_mall_gate_sensor.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mall_gate_sensor.sv
// Doorway direction decoder: two IR beams are synchronised, debounced and decoded into
// single-cycle entry/exit/fault pulses, plus a saturating occupancy count for the full lamp.
module mall_gate_sensor #(
  parameter int DEBOUNCE = 4,
  parameter int TIMEOUT  = 1000,
  parameter int CAPACITY = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       beam_a,
  input  logic       beam_b,
  output logic       entry_pulse,
  output logic       exit_pulse,
  output logic       fault,
  output logic [3:0] occupancy,
  output logic       full,
  output logic       empty
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] IN1   = 3'd1;
  localparam logic [2:0] IN2   = 3'd2;
  localparam logic [2:0] IN3   = 3'd3;
  localparam logic [2:0] OUT1  = 3'd4;
  localparam logic [2:0] OUT2  = 3'd5;
  localparam logic [2:0] OUT3  = 3'd6;
  localparam logic [2:0] ABORT = 3'd7;

  // Filtered beam symbol, bit 0 = A, bit 1 = B.
  localparam logic [1:0] S_NONE = 2'b00;
  localparam logic [1:0] S_A    = 2'b01;
  localparam logic [1:0] S_B    = 2'b10;
  localparam logic [1:0] S_AB   = 2'b11;

  localparam logic [7:0]  DB_LAST  = 8'(DEBOUNCE - 1);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [3:0]  CAP      = 4'(CAPACITY);

  logic [1:0]  sync1;
  logic [1:0]  sync2;
  logic [1:0]  filt;
  logic [7:0]  db_cnt [2];
  logic [2:0]  state;
  logic [2:0]  nxt;
  logic [15:0] tmo_cnt;
  logic        in_passage;
  logic        go_entry;
  logic        go_exit;
  logic        go_fault;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1     <= 2'b00;
      sync2     <= 2'b00;
      filt      <= 2'b00;
      db_cnt[0] <= 8'd0;
      db_cnt[1] <= 8'd0;
    end else begin
      sync1 <= {beam_b, beam_a};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          db_cnt[i] <= 8'd0;
        end else if (db_cnt[i] == DB_LAST) begin
          filt[i]   <= sync2[i];
          db_cnt[i] <= 8'd0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 8'd1;
        end
      end
    end
  end

  assign in_passage = (state != IDLE) && (state != ABORT);

  always_comb begin
    nxt      = state;
    go_entry = 1'b0;
    go_exit  = 1'b0;
    go_fault = 1'b0;
    case (state)
      IDLE: begin
        case (filt)
          S_A:  nxt = IN1;
          S_B:  nxt = OUT1;
          S_AB: begin nxt = ABORT; go_fault = 1'b1; end
          default: ;
        endcase
      end
      IN1: begin
        case (filt)
          S_AB:   nxt = IN2;
          S_NONE: nxt = IDLE;
          S_B:    begin nxt = ABORT; go_fault = 1'b1; end
          default: ;
        endcase
      end
      IN2: begin
        case (filt)
          S_B:    nxt = IN3;
          S_A:    nxt = IN1;
          S_NONE: begin nxt = ABORT; go_fault = 1'b1; end
          default: ;
        endcase
      end
      IN3: begin
        case (filt)
          S_NONE: begin nxt = IDLE; go_entry = 1'b1; end
          S_AB:   nxt = IN2;
          S_A:    begin nxt = ABORT; go_fault = 1'b1; end
          default: ;
        endcase
      end
      OUT1: begin
        case (filt)
          S_AB:   nxt = OUT2;
          S_NONE: nxt = IDLE;
          S_A:    begin nxt = ABORT; go_fault = 1'b1; end
          default: ;
        endcase
      end
      OUT2: begin
        case (filt)
          S_A:    nxt = OUT3;
          S_B:    nxt = OUT1;
          S_NONE: begin nxt = ABORT; go_fault = 1'b1; end
          default: ;
        endcase
      end
      OUT3: begin
        case (filt)
          S_NONE: begin nxt = IDLE; go_exit = 1'b1; end
          S_AB:   nxt = OUT2;
          S_B:    begin nxt = ABORT; go_fault = 1'b1; end
          default: ;
        endcase
      end
      default: begin
        if (filt == S_NONE) nxt = IDLE;
      end
    endcase
    // A stalled passage only times out if the beams did not move it elsewhere this cycle.
    if (in_passage && (nxt == state) && (tmo_cnt == TMO_LAST)) begin
      nxt      = ABORT;
      go_fault = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      tmo_cnt     <= 16'd0;
      entry_pulse <= 1'b0;
      exit_pulse  <= 1'b0;
      fault       <= 1'b0;
      occupancy   <= 4'd0;
    end else begin
      state       <= nxt;
      tmo_cnt     <= ((nxt != state) || !in_passage) ? 16'd0 : tmo_cnt + 16'd1;
      entry_pulse <= go_entry;
      exit_pulse  <= go_exit;
      fault       <= go_fault;
      if (go_entry && (occupancy != CAP)) occupancy <= occupancy + 4'd1;
      else if (go_exit && (occupancy != 4'd0)) occupancy <= occupancy - 4'd1;
    end
  end

  assign full  = (occupancy == CAP);
  assign empty = (occupancy == 4'd0);

endmodule

// File: tb/tb_mall_gate_sensor.sv
// Bench for mall_gate_sensor: directed passages plus random beam activity, checked against
// a sample-window filter model and a position-along-the-doorway direction model.
module tb_mall_gate_sensor;
  localparam int DB  = 4;
  localparam int TMO = 64;
  localparam int CAP = 3;
  localparam int PH  = 20;

  logic       clk    = 1'b0;
  logic       rst    = 1'b0;
  logic       beam_a = 1'b0;
  logic       beam_b = 1'b0;
  logic       entry_pulse, exit_pulse, fault, full, empty;
  logic [3:0] occupancy;

  int vectors = 0;
  int miscompares = 0;

  // DUT-side observation counters and cycle-level disagreement count
  int cyc_bad = 0, n_entry = 0, n_exit = 0, n_fault = 0;

  // reference model state
  logic qa[$];
  logic qb[$];
  logic mfa = 1'b0, mfb = 1'b0;
  int   mdir = 0, mp = 0, np = 0, menter = 0, cyc = 0, eocc = 0;
  logic ex_entry = 1'b0, ex_exit = 1'b0, ex_fault = 1'b0;
  int   m_entry = 0, m_exit = 0, m_fault = 0;

  mall_gate_sensor #(.DEBOUNCE(DB), .TIMEOUT(TMO), .CAPACITY(CAP)) dut (
    .clock(clk), .reset(rst), .beam_a(beam_a), .beam_b(beam_b),
    .entry_pulse(entry_pulse), .exit_pulse(exit_pulse), .fault(fault),
    .occupancy(occupancy), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  // filtered level adopts a new value once the last DB synchronised samples all agree on it;
  // the two newest raw samples are still inside the synchroniser
  function automatic logic settle(input logic q[$], input logic cur);
    int n;
    logic v;
    n = q.size();
    v = q[n-3];
    for (int j = 0; j < DB; j++) if (q[n-3-j] != v) return cur;
    return v;
  endfunction

  // position along the walking direction: first beam = 1, both = 2, second beam = 3
  function automatic int pos_of(input logic first, input logic second);
    if (first && !second) return 1;
    if (first && second) return 2;
    if (!first && second) return 3;
    return 0;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        qa.delete(); qb.delete();
        repeat (DB + 2) begin qa.push_back(1'b0); qb.push_back(1'b0); end
        mfa = 1'b0; mfb = 1'b0; mdir = 0; mp = 0; menter = 0; cyc = 0; eocc = 0;
        ex_entry = 1'b0; ex_exit = 1'b0; ex_fault = 1'b0;
      end else begin
        cyc++;
        ex_entry = 1'b0; ex_exit = 1'b0; ex_fault = 1'b0;
        if (mdir == 0) begin
          if (mfa && mfb) begin ex_fault = 1'b1; mdir = 3; end
          else if (mfa || mfb) begin mdir = mfa ? 1 : 2; mp = 1; menter = cyc; end
        end else if (mdir == 3) begin
          if (!mfa && !mfb) mdir = 0;
        end else begin
          np = (mdir == 1) ? pos_of(mfa, mfb) : pos_of(mfb, mfa);
          if (np == mp) begin
            if (cyc - menter == TMO) begin ex_fault = 1'b1; mdir = 3; end
          end else if (np == 0) begin
            if (mp == 3) begin
              if (mdir == 1) ex_entry = 1'b1; else ex_exit = 1'b1;
              mdir = 0;
            end else if (mp == 1) mdir = 0;
            else begin ex_fault = 1'b1; mdir = 3; end
          end else if (np - mp == 1 || mp - np == 1) begin
            mp = np; menter = cyc;
          end else begin
            ex_fault = 1'b1; mdir = 3;
          end
        end
        if (ex_entry) begin m_entry++; if (eocc < CAP) eocc++; end
        if (ex_exit) begin m_exit++; if (eocc > 0) eocc--; end
        if (ex_fault) m_fault++;
        qa.push_back(beam_a); qb.push_back(beam_b);
        mfa = settle(qa, mfa); mfb = settle(qb, mfb);
        qa.delete(0); qb.delete(0);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if ({entry_pulse, exit_pulse, fault, occupancy, full, empty} !==
            {ex_entry, ex_exit, ex_fault, 4'(eocc), eocc == CAP, eocc == 0}) cyc_bad++;
        if (entry_pulse === 1'b1) n_entry++;
        if (exit_pulse === 1'b1) n_exit++;
        if (fault === 1'b1) n_fault++;
      end
    end
  end

  task automatic hold(input logic a, input logic b, input int n);
    beam_a = a; beam_b = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic pass_in();
    hold(1, 0, PH); hold(1, 1, PH); hold(0, 1, PH); hold(0, 0, PH);
  endtask

  task automatic pass_out();
    hold(0, 1, PH); hold(1, 1, PH); hold(1, 0, PH); hold(0, 0, PH);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({entry_pulse, exit_pulse, fault, occupancy, full, empty} !== 9'b0_0_0_0000_0_1) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want 000000001",
               {entry_pulse, exit_pulse, fault, occupancy, full, empty});
    end
    rst = 1'b0;
    hold(0, 0, 5);
  endtask

  task automatic test_inward();
    int e0, b0, lat;
    e0 = n_entry; b0 = cyc_bad; lat = -1;
    hold(1, 0, PH); hold(1, 1, PH); hold(0, 1, PH);
    beam_a = 1'b0; beam_b = 1'b0;
    for (int i = 1; i <= PH; i++) begin
      @(negedge clk);
      if (entry_pulse === 1'b1 && lat < 0) lat = i;
    end
    vectors++; if (lat != DB + 3) begin miscompares++; $display("FAIL inward_latency: got %0d want %0d", lat, DB + 3); end
    vectors++; if (n_entry - e0 != 1) begin miscompares++; $display("FAIL inward_pulses: got %0d want 1", n_entry - e0); end
    vectors++; if (occupancy !== 4'd1) begin miscompares++; $display("FAIL inward_occ: got %0d want 1", occupancy); end
    vectors++; if (empty !== 1'b0) begin miscompares++; $display("FAIL inward_empty: got %b want 0", empty); end
    vectors++; if (cyc_bad != b0) begin miscompares++; $display("FAIL inward_model: got %0d bad cycles want 0", cyc_bad - b0); end
  endtask

  task automatic test_outward();
    int x0, e0;
    x0 = n_exit; e0 = n_entry;
    pass_out();
    vectors++; if (n_exit - x0 != 1) begin miscompares++; $display("FAIL outward_pulses: got %0d want 1", n_exit - x0); end
    vectors++; if (n_entry != e0) begin miscompares++; $display("FAIL outward_entry: got %0d want 0", n_entry - e0); end
    vectors++; if (occupancy !== 4'd0) begin miscompares++; $display("FAIL outward_occ: got %0d want 0", occupancy); end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL outward_empty: got %b want 1", empty); end
  endtask

  task automatic test_backout();
    int p0, f0, b0;
    p0 = n_entry + n_exit; f0 = n_fault; b0 = cyc_bad;
    hold(1, 0, PH); hold(1, 1, PH); hold(1, 0, PH); hold(0, 0, PH);
    vectors++; if (n_entry + n_exit != p0 || n_fault != f0) begin
      miscompares++; $display("FAIL backout_events: got %0d pulses %0d faults want 0 0", n_entry + n_exit - p0, n_fault - f0);
    end
    vectors++; if (occupancy !== 4'd0) begin miscompares++; $display("FAIL backout_occ: got %0d want 0", occupancy); end
    hold(0, 1, 3); hold(0, 0, PH);
    vectors++; if (n_entry + n_exit != p0 || n_fault != f0) begin
      miscompares++; $display("FAIL glitch_events: got %0d pulses %0d faults want 0 0", n_entry + n_exit - p0, n_fault - f0);
    end
    vectors++; if (cyc_bad != b0) begin miscompares++; $display("FAIL backout_model: got %0d bad cycles want 0", cyc_bad - b0); end
  endtask

  task automatic test_saturation();
    int e0;
    e0 = n_entry;
    for (int p = 1; p <= 5; p++) begin
      pass_in();
      vectors++; if (occupancy !== 4'((p < CAP) ? p : CAP)) begin
        miscompares++; $display("FAIL sat_occ_%0d: got %0d want %0d", p, occupancy, (p < CAP) ? p : CAP);
      end
      vectors++; if (full !== (p >= CAP)) begin miscompares++; $display("FAIL sat_full_%0d: got %b want %b", p, full, p >= CAP); end
    end
    vectors++; if (n_entry - e0 != 5) begin miscompares++; $display("FAIL sat_pulses: got %0d want 5", n_entry - e0); end
    pass_out();
    vectors++; if (occupancy !== 4'd2) begin miscompares++; $display("FAIL sat_exit_occ: got %0d want 2", occupancy); end
    vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL sat_exit_full: got %b want 0", full); end
  endtask

  task automatic test_abort();
    int f0, e0, lat;
    f0 = n_fault; e0 = n_entry; lat = -1;
    hold(1, 1, PH);
    vectors++; if (n_fault - f0 != 1) begin miscompares++; $display("FAIL abort_both_fault: got %0d want 1", n_fault - f0); end
    hold(1, 0, PH); hold(0, 0, PH);
    vectors++; if (n_fault - f0 != 1 || n_entry != e0) begin
      miscompares++; $display("FAIL abort_wait: got %0d faults %0d entries want 1 0", n_fault - f0, n_entry - e0);
    end
    beam_a = 1'b1; beam_b = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (fault === 1'b1 && lat < 0) lat = i;
    end
    vectors++; if (lat != DB + 3 + TMO) begin miscompares++; $display("FAIL timeout_latency: got %0d want %0d", lat, DB + 3 + TMO); end
    hold(1, 1, PH); hold(0, 1, PH); hold(0, 0, PH);
    vectors++; if (n_entry != e0) begin miscompares++; $display("FAIL timeout_entry: got %0d want 0", n_entry - e0); end
    vectors++; if (n_fault - f0 != 2) begin miscompares++; $display("FAIL timeout_faults: got %0d want 2", n_fault - f0); end
    vectors++; if (occupancy !== 4'd2) begin miscompares++; $display("FAIL abort_occ: got %0d want 2", occupancy); end
  endtask

  task automatic test_reset_mid();
    int b0;
    hold(1, 0, PH); hold(1, 1, 10);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({entry_pulse, exit_pulse, fault, occupancy, full, empty} !== 9'b0_0_0_0000_0_1) begin
      miscompares++;
      $display("FAIL midreset_outputs: got %b want 000000001",
               {entry_pulse, exit_pulse, fault, occupancy, full, empty});
    end
    beam_a = 1'b0; beam_b = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    b0 = cyc_bad;
    hold(0, 0, 5);
    pass_in();
    vectors++; if (occupancy !== 4'd1) begin miscompares++; $display("FAIL midreset_occ: got %0d want 1", occupancy); end
    vectors++; if (cyc_bad != b0) begin miscompares++; $display("FAIL midreset_model: got %0d bad cycles want 0", cyc_bad - b0); end
  endtask

  task automatic test_random();
    int e0, x0, f0, me0, mx0, mf0, b0, n;
    e0 = n_entry; x0 = n_exit; f0 = n_fault; b0 = cyc_bad;
    me0 = m_entry; mx0 = m_exit; mf0 = m_fault;
    for (int s = 0; s < 200; s++) begin
      n = ($urandom_range(0, 19) == 0) ? 80 : $urandom_range(1, 14);
      hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), n);
    end
    hold(0, 0, 30);
    vectors++; if (n_entry - e0 != m_entry - me0) begin miscompares++; $display("FAIL rand_entries: got %0d want %0d", n_entry - e0, m_entry - me0); end
    vectors++; if (n_exit - x0 != m_exit - mx0) begin miscompares++; $display("FAIL rand_exits: got %0d want %0d", n_exit - x0, m_exit - mx0); end
    vectors++; if (n_fault - f0 != m_fault - mf0) begin miscompares++; $display("FAIL rand_faults: got %0d want %0d", n_fault - f0, m_fault - mf0); end
    vectors++; if (occupancy !== 4'(eocc)) begin miscompares++; $display("FAIL rand_occ: got %0d want %0d", occupancy, eocc); end
    vectors++; if (cyc_bad != b0) begin miscompares++; $display("FAIL rand_model: got %0d bad cycles want 0", cyc_bad - b0); end
  endtask

  initial begin
    test_reset();
    test_inward();
    test_outward();
    test_backout();
    test_saturation();
    test_abort();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
